// File: rtl/pulse_sequencer.sv
// pulse_sequencer: walks a contiguous run of pulse descriptors, waits on a
// sequence-relative timer until each descriptor's t_start, then plays the
// pulse (frequency/phase/amplitude) for t_len cycles.
//
// Handshake: there is no valid/ready pair here. start is a level sampled only
// in IDLE; abort is a level sampled in every non-IDLE state and wins over all
// other activity. Descriptor data from pulse_fetch is trusted exactly one
// cycle after fetch_addr is presented (the LOAD state), with no back-pressure.
module pulse_sequencer #(
  parameter int ADDR_W = 5,
  parameter int TIME_W = 28,
  parameter int LEN_W  = 20
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   num_pulses,
  input  logic              abort,
  output logic [31:0]       fetch_addr,
  input  logic [31:0]       f_frequency,
  input  logic [15:0]       f_phase,
  input  logic [13:0]       f_amplitude,
  input  logic [TIME_W-1:0] f_t_start,
  input  logic [LEN_W-1:0]  f_t_len,
  output logic              pulse_valid,
  output logic [31:0]       pulse_frequency,
  output logic [15:0]       pulse_phase,
  output logic [13:0]       pulse_amplitude,
  output logic [TIME_W-1:0] timer,
  output logic              busy,
  output logic              done,
  output logic              late,
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LOAD  = 3'd2,
    S_WAIT  = 3'd3,
    S_PLAY  = 3'd4,
    S_FIN   = 3'd5
  } state_t;

  state_t              state_q;
  logic [ADDR_W-1:0]   base_q;
  logic [ADDR_W:0]     count_q;
  logic [ADDR_W-1:0]   idx_q;
  logic [ADDR_W-1:0]   fetch_addr_q;
  logic [31:0]         freq_q;
  logic [15:0]         phase_q;
  logic [13:0]         amp_q;
  logic [TIME_W-1:0]   t_start_q;
  logic [LEN_W-1:0]    play_cnt_q;
  logic [TIME_W-1:0]   timer_q;
  logic                pulse_valid_q;
  logic                busy_q;
  logic                done_q;
  logic                late_q;

  // Next-value helpers; timer comparisons use one extra bit so timer+1 never wraps.
  logic [TIME_W:0]     timer_next_d;
  logic [ADDR_W-1:0]   idx_d;
  logic [ADDR_W-1:0]   next_addr_d;
  logic                last_pulse_d;

  // Derived values for the NEXT decision and the t_start comparisons.
  always_comb begin
    timer_next_d = {1'b0, timer_q} + (TIME_W+1)'(1);
    idx_d        = idx_q + ADDR_W'(1);
    next_addr_d  = base_q + idx_d;
    last_pulse_d = (({1'b0, idx_q} + (ADDR_W+1)'(1)) == count_q);
  end

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      base_q        <= '0;
      count_q       <= '0;
      idx_q         <= '0;
      fetch_addr_q  <= '0;
      freq_q        <= '0;
      phase_q       <= '0;
      amp_q         <= '0;
      t_start_q     <= '0;
      play_cnt_q    <= '0;
      timer_q       <= '0;
      pulse_valid_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      late_q        <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (busy_q) timer_q <= timer_q + TIME_W'(1);
      if (state_q != S_IDLE && abort) begin
        // Abort drops the pulse at once; late is kept for software to inspect.
        state_q       <= S_IDLE;
        busy_q        <= 1'b0;
        pulse_valid_q <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (start) begin
              base_q  <= base_addr;
              count_q <= num_pulses;
              idx_q   <= '0;
              timer_q <= '0;
              late_q  <= 1'b0;
              busy_q  <= 1'b1;
              if (num_pulses != '0) begin
                fetch_addr_q <= base_addr;
                state_q      <= S_FETCH;
              end else begin
                done_q  <= 1'b1;
                state_q <= S_FIN;
              end
            end
          end
          S_FETCH: state_q <= S_LOAD;
          S_LOAD: begin
            freq_q     <= f_frequency;
            phase_q    <= f_phase;
            amp_q      <= f_amplitude;
            t_start_q  <= f_t_start;
            play_cnt_q <= f_t_len;
            if (f_t_len == '0) begin
              // Zero-length descriptor: skip straight to the NEXT decision.
              if (last_pulse_d) begin
                done_q  <= 1'b1;
                state_q <= S_FIN;
              end else begin
                idx_q        <= idx_d;
                fetch_addr_q <= next_addr_d;
                state_q      <= S_FETCH;
              end
            end else if ({1'b0, f_t_start} > timer_next_d) begin
              state_q <= S_WAIT;
            end else begin
              pulse_valid_q <= 1'b1;
              state_q       <= S_PLAY;
              if ({1'b0, f_t_start} < timer_next_d) late_q <= 1'b1;
            end
          end
          S_WAIT: begin
            if (timer_next_d == {1'b0, t_start_q}) begin
              pulse_valid_q <= 1'b1;
              state_q       <= S_PLAY;
            end
          end
          S_PLAY: begin
            if (play_cnt_q == LEN_W'(1)) begin
              pulse_valid_q <= 1'b0;
              if (last_pulse_d) begin
                done_q  <= 1'b1;
                state_q <= S_FIN;
              end else begin
                idx_q        <= idx_d;
                fetch_addr_q <= next_addr_d;
                state_q      <= S_FETCH;
              end
            end else begin
              play_cnt_q <= play_cnt_q - LEN_W'(1);
            end
          end
          S_FIN: begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign fetch_addr      = {{(32-ADDR_W){1'b0}}, fetch_addr_q};
  assign pulse_valid     = pulse_valid_q;
  assign pulse_frequency = freq_q;
  assign pulse_phase     = phase_q;
  assign pulse_amplitude = pulse_valid_q ? amp_q : 14'd0;
  assign timer           = timer_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign late            = late_q;
  assign dbg_state       = state_q;

endmodule

// File: tb/tb_pulse_sequencer.sv
// Testbench for pulse_sequencer: a registered descriptor memory stands in for
// pulse_fetch; a table of single-pulse sequences plus hand-written multi-pulse,
// wrap, zero-count, abort and reset scenarios.
module tb_pulse_sequencer;
  localparam int ADDR_W = 5;
  localparam int TIME_W = 28;
  localparam int LEN_W  = 20;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [ADDR_W:0]   num_pulses = '0;
  logic              abort = 1'b0;
  logic [31:0]       fetch_addr;
  logic [31:0]       f_frequency = '0;
  logic [15:0]       f_phase = '0;
  logic [13:0]       f_amplitude = '0;
  logic [TIME_W-1:0] f_t_start = '0;
  logic [LEN_W-1:0]  f_t_len = '0;
  logic              pulse_valid;
  logic [31:0]       pulse_frequency;
  logic [15:0]       pulse_phase;
  logic [13:0]       pulse_amplitude;
  logic [TIME_W-1:0] timer;
  logic              busy;
  logic              done;
  logic              late;
  logic [2:0]        dbg_state;

  pulse_sequencer #(.ADDR_W(ADDR_W), .TIME_W(TIME_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .num_pulses(num_pulses), .abort(abort), .fetch_addr(fetch_addr),
    .f_frequency(f_frequency), .f_phase(f_phase), .f_amplitude(f_amplitude),
    .f_t_start(f_t_start), .f_t_len(f_t_len), .pulse_valid(pulse_valid),
    .pulse_frequency(pulse_frequency), .pulse_phase(pulse_phase),
    .pulse_amplitude(pulse_amplitude), .timer(timer), .busy(busy),
    .done(done), .late(late), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- descriptor memory model ----------------
  typedef struct {
    logic [31:0]       freq;
    logic [15:0]       phase;
    logic [13:0]       amp;
    logic [TIME_W-1:0] t_start;
    logic [LEN_W-1:0]  t_len;
  } desc_t;

  desc_t mem [32];

  always @(posedge clk) begin
    f_frequency <= mem[fetch_addr[4:0]].freq;
    f_phase     <= mem[fetch_addr[4:0]].phase;
    f_amplitude <= mem[fetch_addr[4:0]].amp;
    f_t_start   <= mem[fetch_addr[4:0]].t_start;
    f_t_len     <= mem[fetch_addr[4:0]].t_len;
  end

  // ---------------- scoreboard state ----------------
  logic [31:0] exp_q[$];
  logic [13:0] exp_amp_q[$];
  int          err_cnt = 0;
  int          chk_cnt = 0;

  int          first_play;
  int          play_cycles;
  int          done_timer;
  int          done_cnt;
  logic        obs_late;
  logic        prev_valid;
  logic [31:0] obs_addr_q[$];
  int          obs_start_q[$];
  logic [31:0] cur_freq;
  logic [13:0] cur_amp;

  task automatic check(input string name, input longint act, input longint exp);
    chk_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_desc(input int a, input int ts, input int len,
                          input logic [31:0] fr, input logic [13:0] am);
    mem[a].freq    = fr;
    mem[a].phase   = fr[31:16];
    mem[a].amp     = am;
    mem[a].t_start = TIME_W'(ts);
    mem[a].t_len   = LEN_W'(len);
  endtask

  task automatic push_exp(input logic [31:0] fr, input logic [13:0] am);
    exp_q.push_back(fr);
    exp_amp_q.push_back(am);
  endtask

  task automatic clear_obs();
    first_play  = -1;
    play_cycles = 0;
    done_timer  = -1;
    done_cnt    = 0;
    obs_late    = 1'b0;
    prev_valid  = 1'b0;
    obs_addr_q.delete();
    obs_start_q.delete();
  endtask

  // ---------------- driver tasks ----------------
  task automatic launch(input int b, input int cnt, input logic with_abort);
    base_addr  = ADDR_W'(b);
    num_pulses = (ADDR_W+1)'(cnt);
    start      = 1'b1;
    abort      = with_abort;
    step();
    start      = 1'b0;
    abort      = 1'b0;
  endtask

  // Samples every cycle until busy drops; checks pulse contents against the queue.
  task automatic monitor(input int budget);
    int n = 0;
    while (n < budget) begin
      if (obs_addr_q.size() == 0 || obs_addr_q[$] != fetch_addr)
        obs_addr_q.push_back(fetch_addr);
      if (pulse_valid) begin
        if (!prev_valid) begin
          obs_start_q.push_back(int'(timer));
          if (first_play < 0) first_play = int'(timer);
          if (exp_q.size() == 0) begin
            chk_cnt++;
            err_cnt++;
            $display("FAIL unexpected_pulse: pulse at timer %0d, none expected", timer);
            cur_freq = '0;
            cur_amp  = '0;
          end else begin
            cur_freq = exp_q.pop_front();
            cur_amp  = exp_amp_q.pop_front();
          end
        end
        play_cycles++;
        check("pulse_frequency", pulse_frequency, cur_freq);
        check("pulse_phase", pulse_phase, cur_freq[31:16]);
        check("pulse_amplitude", pulse_amplitude, cur_amp);
      end else begin
        check("amp_zero_when_idle", pulse_amplitude, 0);
      end
      if (done) begin
        done_cnt++;
        done_timer = int'(timer);
      end
      obs_late   = late;
      prev_valid = pulse_valid;
      if (!busy) break;
      step();
      n++;
    end
    check("seq_terminated", (n < budget) ? 1 : 0, 1);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int          base;
    int          t_start;
    int          t_len;
    logic [31:0] freq;
    logic [13:0] amp;
    int          exp_first;
    int          exp_cycles;
    int          exp_done;
    logic        exp_late;
  } vec_t;

  vec_t vecs [6];

  initial begin
    for (int i = 0; i < 32; i++) set_desc(i, 0, 0, 32'h0, 14'h0);

    vecs[0] = '{3,  10, 4, 32'h1234_5678, 14'h1FFF, 10, 4, 14, 1'b0};
    vecs[1] = '{7,  2,  1, 32'hA5A5_A5A5, 14'h0001, 2,  1, 3,  1'b0};
    vecs[2] = '{12, 0,  2, 32'h0BAD_F00D, 14'h2AAA, 2,  2, 4,  1'b1};
    vecs[3] = '{31, 1,  3, 32'hDEAD_BEEF, 14'h1555, 2,  3, 5,  1'b1};
    vecs[4] = '{0,  3,  5, 32'h0000_0001, 14'h3FFF, 3,  5, 8,  1'b0};
    vecs[5] = '{20, 7,  0, 32'h1111_1111, 14'h0123, -1, 0, 2,  1'b0};

    // reset
    step();
    step();
    rst_n = 1'b1;
    step();
    check("rst_pulse_valid", pulse_valid, 0);
    check("rst_fetch_addr", fetch_addr, 0);
    check("rst_timer", timer, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_late", late, 0);
    check("rst_freq", pulse_frequency, 0);
    check("rst_amp", pulse_amplitude, 0);

    // single-pulse table
    for (int v = 0; v < 6; v++) begin
      clear_obs();
      set_desc(vecs[v].base, vecs[v].t_start, vecs[v].t_len, vecs[v].freq, vecs[v].amp);
      if (vecs[v].t_len > 0) push_exp(vecs[v].freq, vecs[v].amp);
      launch(vecs[v].base, 1, 1'b0);
      monitor(100);
      check("vec_fetch_addr", obs_addr_q[0], vecs[v].base);
      check("vec_first_play", first_play, vecs[v].exp_first);
      check("vec_play_cycles", play_cycles, vecs[v].exp_cycles);
      check("vec_done_timer", done_timer, vecs[v].exp_done);
      check("vec_done_count", done_cnt, 1);
      check("vec_late", obs_late, vecs[v].exp_late);
      check("vec_exp_drained", exp_q.size(), 0);
    end

    // back-to-back, second pulse inside the turnaround gap -> late
    clear_obs();
    set_desc(8, 5, 3, 32'hCAFE_0001, 14'h0101);
    set_desc(9, 8, 2, 32'hCAFE_0002, 14'h0202);
    push_exp(32'hCAFE_0001, 14'h0101);
    push_exp(32'hCAFE_0002, 14'h0202);
    launch(8, 2, 1'b0);
    monitor(100);
    check("b2b_late_start0", obs_start_q[0], 5);
    check("b2b_late_start1", obs_start_q[1], 10);
    check("b2b_late_cycles", play_cycles, 5);
    check("b2b_late_done", done_timer, 12);
    check("b2b_late_flag", obs_late, 1);

    // back-to-back, second pulse exactly at the turnaround -> on time
    clear_obs();
    set_desc(9, 10, 2, 32'hCAFE_0002, 14'h0202);
    push_exp(32'hCAFE_0001, 14'h0101);
    push_exp(32'hCAFE_0002, 14'h0202);
    launch(8, 2, 1'b0);
    monitor(100);
    check("b2b_ok_start1", obs_start_q[1], 10);
    check("b2b_ok_done", done_timer, 12);
    check("b2b_ok_flag", obs_late, 0);

    // address wrap 30,31,0,1
    clear_obs();
    set_desc(30, 2,  1, 32'h3000_0030, 14'h0030);
    set_desc(31, 5,  1, 32'h3100_0031, 14'h0031);
    set_desc(0,  8,  1, 32'h0000_1000, 14'h0100);
    set_desc(1,  11, 1, 32'h0100_1001, 14'h0101);
    push_exp(32'h3000_0030, 14'h0030);
    push_exp(32'h3100_0031, 14'h0031);
    push_exp(32'h0000_1000, 14'h0100);
    push_exp(32'h0100_1001, 14'h0101);
    launch(30, 4, 1'b0);
    monitor(100);
    check("wrap_addr_count", obs_addr_q.size(), 4);
    check("wrap_addr0", obs_addr_q[0], 30);
    check("wrap_addr1", obs_addr_q[1], 31);
    check("wrap_addr2", obs_addr_q[2], 0);
    check("wrap_addr3", obs_addr_q[3], 1);
    check("wrap_pulses", obs_start_q.size(), 4);
    check("wrap_start3", obs_start_q[3], 11);
    check("wrap_done_count", done_cnt, 1);
    check("wrap_done_timer", done_timer, 12);
    check("wrap_late", obs_late, 0);

    // zero-length descriptor in the middle of a run
    clear_obs();
    set_desc(14, 3, 2, 32'h1400_0014, 14'h0014);
    set_desc(15, 4, 0, 32'h1500_0015, 14'h0015);
    set_desc(16, 9, 1, 32'h1600_0016, 14'h0016);
    push_exp(32'h1400_0014, 14'h0014);
    push_exp(32'h1600_0016, 14'h0016);
    launch(14, 3, 1'b0);
    monitor(100);
    check("skip_addr_count", obs_addr_q.size(), 3);
    check("skip_start0", obs_start_q[0], 3);
    check("skip_start1", obs_start_q[1], 9);
    check("skip_cycles", play_cycles, 3);
    check("skip_done_timer", done_timer, 10);

    // count = 0: done with no fetch, fetch_addr stays at 16
    clear_obs();
    launch(5, 0, 1'b0);
    monitor(10);
    check("zero_done_count", done_cnt, 1);
    check("zero_done_timer", done_timer, 0);
    check("zero_no_pulse", play_cycles, 0);
    check("zero_no_fetch", obs_addr_q.size(), 1);
    check("zero_fetch_addr", obs_addr_q[0], 16);

    // abort in the second cycle of a late 6-cycle pulse
    set_desc(4, 0, 6, 32'h0404_0404, 14'h0404);
    launch(4, 1, 1'b0);
    step();
    step();
    check("abort_pulse_on", pulse_valid, 1);
    check("abort_amp_on", pulse_amplitude, 14'h0404);
    step();
    check("abort_pulse_cycle2", pulse_valid, 1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_valid_off", pulse_valid, 0);
    check("abort_amp_off", pulse_amplitude, 0);
    check("abort_busy_off", busy, 0);
    check("abort_no_done", done, 0);
    check("abort_late_kept", late, 1);
    step();
    check("abort_no_done_later", done, 0);
    check("abort_idle_later", busy, 0);

    // start+abort together in IDLE: start wins, sequence runs normally
    clear_obs();
    push_exp(32'h1234_5678, 14'h1FFF);
    launch(3, 1, 1'b1);
    check("startabort_busy", busy, 1);
    check("startabort_timer", timer, 0);
    monitor(100);
    check("restart_first_play", first_play, 10);
    check("restart_done_timer", done_timer, 14);
    check("restart_late_cleared", obs_late, 0);

    // start ignored while busy
    clear_obs();
    set_desc(5, 6, 2, 32'h0505_0505, 14'h0505);
    push_exp(32'h0505_0505, 14'h0505);
    launch(5, 1, 1'b0);
    step();
    step();
    base_addr  = 5'd9;
    num_pulses = 6'd1;
    start      = 1'b1;
    step();
    start      = 1'b0;
    check("busy_start_timer", timer, 3);
    check("busy_start_addr", fetch_addr, 5);
    monitor(100);
    check("busy_start_first", first_play, 6);
    check("busy_start_done", done_timer, 8);
    check("busy_start_addrs", obs_addr_q.size(), 1);

    // asynchronous reset during WAIT
    set_desc(6, 20, 3, 32'h0606_0606, 14'h0606);
    launch(6, 1, 1'b0);
    step();
    step();
    step();
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_timer", timer, 0);
    check("arst_fetch_addr", fetch_addr, 0);
    check("arst_freq", pulse_frequency, 0);
    check("arst_phase", pulse_phase, 0);
    check("arst_valid", pulse_valid, 0);
    check("arst_done", done, 0);
    check("arst_late", late, 0);
    #1;
    rst_n = 1'b1;
    step();
    step();
    check("arst_stays_idle", busy, 0);
    check("arst_no_done", done, 0);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end
endmodule
